// File: rtl/cb_updn_mod_cnt.sv
// Cascadable up/down counter with programmable modulus, synchronous load,
// wrap-or-saturate at terminal count, registered terminal pulse and sticky overflow.
module cb_updn_mod_cnt #(
    parameter int     WIDTH     = 8,
    parameter longint MODULUS   = 256,
    parameter longint RESET_VAL = 0,
    parameter bit     WRAP      = 1'b1
) (
    input  logic             CLK,
    input  logic             CDN,
    input  logic             EN,
    input  logic             CAI,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             TCP,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

    if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 || MODULUS > (longint'(1) << WIDTH) ||
        RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
        $error("cb_updn_mod_cnt: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tcp_q, tcp_d;
    logic             ovf_q, ovf_d;
    logic             at_term;
    logic             step;
    logic             carry_evt;

    // The terminal value follows UP combinationally, so a direction change
    // takes effect on the very next edge.
    assign at_term   = UP ? (cnt_q == MAX_VAL) : (cnt_q == '0);
    assign step      = EN & CAI & ~LD;
    assign carry_evt = step & at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (LD) begin
            // D can only exceed MAX_VAL when MODULUS < 2**WIDTH.
            cnt_d = (D > MAX_VAL) ? MAX_VAL : D;
        end else if (step && !at_term) begin
            cnt_d = UP ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
        end else if (carry_evt && WRAP) begin
            cnt_d = UP ? '0 : MAX_VAL;
        end
    end

    always_comb begin
        tcp_d = carry_evt;
        ovf_d = ovf_q;
        if (carry_evt) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            cnt_q <= RST_VAL;
            tcp_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tcp_q <= tcp_d;
            ovf_q <= ovf_d;
        end
    end

    // Carry-out ignores LD: chained stages share LD and see it themselves.
    assign CAO = EN & CAI & at_term;
    assign Q   = cnt_q;
    assign TCP = tcp_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_cb_updn_mod_cnt.sv
// Bench for cb_updn_mod_cnt: wrap and saturate decade counters driven in parallel,
// plus a two-digit decade cascade, checked against an arithmetic model every cycle.
module tb_cb_updn_mod_cnt;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       cdn;
    logic       en, cai, up, ld, clr;
    logic [3:0] d;
    logic       c_en;

    logic [3:0] w_q, s_q, lo_q, hi_q;
    logic       w_cao, w_tcp, w_ovf;
    logic       s_cao, s_tcp, s_ovf;
    logic       lo_cao, lo_tcp, lo_ovf;
    logic       hi_cao, hi_tcp, hi_ovf;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cb_updn_mod_cnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .WRAP(1'b1)) u_wrap (
        .CLK(clk), .CDN(cdn), .EN(en), .CAI(cai), .UP(up), .LD(ld), .D(d),
        .CLR_OVF(clr), .Q(w_q), .CAO(w_cao), .TCP(w_tcp), .OVF(w_ovf));

    cb_updn_mod_cnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .WRAP(1'b0)) u_sat (
        .CLK(clk), .CDN(cdn), .EN(en), .CAI(cai), .UP(up), .LD(ld), .D(d),
        .CLR_OVF(clr), .Q(s_q), .CAO(s_cao), .TCP(s_tcp), .OVF(s_ovf));

    cb_updn_mod_cnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .WRAP(1'b1)) u_lo (
        .CLK(clk), .CDN(cdn), .EN(c_en), .CAI(1'b1), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .CLR_OVF(1'b0), .Q(lo_q), .CAO(lo_cao), .TCP(lo_tcp), .OVF(lo_ovf));

    cb_updn_mod_cnt #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .WRAP(1'b1)) u_hi (
        .CLK(clk), .CDN(cdn), .EN(c_en), .CAI(lo_cao), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .CLR_OVF(1'b0), .Q(hi_q), .CAO(hi_cao), .TCP(hi_tcp), .OVF(hi_ovf));

    // ---------------- model: index 0 = wrap, 1 = saturate ----------------
    int m_q[2]   = '{0, 0};
    bit m_tcp[2] = '{1'b0, 1'b0};
    bit m_ovf[2] = '{1'b0, 1'b0};
    int c_cnt    = 0;
    bit c_lo_tcp = 1'b0;
    bit c_hi_tcp = 1'b0;
    bit c_hi_ovf = 1'b0;
    int n_val;
    bit n_hit;

    always @(posedge clk or negedge cdn) begin
        if (!cdn) begin
            for (int i = 0; i < 2; i++) begin
                m_q[i] = 0; m_tcp[i] = 1'b0; m_ovf[i] = 1'b0;
            end
            c_cnt = 0; c_lo_tcp = 1'b0; c_hi_tcp = 1'b0; c_hi_ovf = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_hit = 1'b0;
                n_val = m_q[i];
                if (ld) begin
                    n_val = (int'(d) >= M) ? M - 1 : int'(d);
                end else if (en && cai) begin
                    n_val = up ? m_q[i] + 1 : m_q[i] - 1;
                    if (n_val < 0 || n_val >= M) begin
                        n_hit = 1'b1;
                        n_val = (i == 0) ? (n_val + M) % M : m_q[i];
                    end
                end
                m_tcp[i] = n_hit;
                m_ovf[i] = n_hit | (m_ovf[i] & ~clr);
                m_q[i]   = n_val;
            end
            c_lo_tcp = c_en && (c_cnt % 10 == 9);
            c_hi_tcp = c_en && (c_cnt == 99);
            c_hi_ovf = c_hi_ovf | c_hi_tcp;
            if (c_en) c_cnt = (c_cnt + 1) % 100;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit exp_cao(input int q);
        return en && cai && (q == (up ? M - 1 : 0));
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("w_q",    32'(w_q),    32'(m_q[0]));
            check("w_tcp",  32'(w_tcp),  32'(m_tcp[0]));
            check("w_ovf",  32'(w_ovf),  32'(m_ovf[0]));
            check("w_cao",  32'(w_cao),  32'(exp_cao(m_q[0])));
            check("s_q",    32'(s_q),    32'(m_q[1]));
            check("s_tcp",  32'(s_tcp),  32'(m_tcp[1]));
            check("s_ovf",  32'(s_ovf),  32'(m_ovf[1]));
            check("s_cao",  32'(s_cao),  32'(exp_cao(m_q[1])));
            check("lo_q",   32'(lo_q),   32'(c_cnt % 10));
            check("hi_q",   32'(hi_q),   32'(c_cnt / 10));
            check("lo_tcp", 32'(lo_tcp), 32'(c_lo_tcp));
            check("hi_tcp", 32'(hi_tcp), 32'(c_hi_tcp));
            check("hi_ovf", 32'(hi_ovf), 32'(c_hi_ovf));
            check("lo_cao", 32'(lo_cao), 32'(c_en && (c_cnt % 10 == 9)));
            check("hi_cao", 32'(hi_cao), 32'(c_en && (c_cnt == 99)));
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int n_hi_pulse;

    initial begin
        cdn = 1'b0; en = 1'b0; cai = 1'b1; up = 1'b1; ld = 1'b0; clr = 1'b0;
        d = 4'd0; c_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_w_q", 32'(w_q), 32'd0);
        check("rst_w_tcp", 32'(w_tcp), 32'd0);
        check("rst_w_ovf", 32'(w_ovf), 32'd0);
        cdn = 1'b1;
        chk_on = 1'b1;

        // Up count with wrap / saturate at 9.
        en = 1'b1; cai = 1'b1; up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 9)  check("up9_w_cao", 32'(w_cao), 32'd1);
            if (k == 10) begin
                check("wrap_w_q", 32'(w_q), 32'd0);
                check("wrap_w_tcp", 32'(w_tcp), 32'd1);
                check("wrap_w_ovf", 32'(w_ovf), 32'd1);
                check("sat_s_q", 32'(s_q), 32'd9);
            end
            if (k == 11) begin
                check("after_w_q", 32'(w_q), 32'd1);
                check("after_w_tcp", 32'(w_tcp), 32'd0);
                check("sat_s_tcp_held", 32'(s_tcp), 32'd1);
            end
        end

        // Load 2 with OVF clear, then count down 4 edges.
        ld = 1'b1; d = 4'd2; up = 1'b0; clr = 1'b1;
        step();
        check("ld2_s_q", 32'(s_q), 32'd2);
        check("ld2_s_ovf", 32'(s_ovf), 32'd0);
        ld = 1'b0; clr = 1'b0;
        repeat (4) step();
        check("dn_s_q", 32'(s_q), 32'd0);
        check("dn_s_tcp", 32'(s_tcp), 32'd1);
        check("dn_s_ovf", 32'(s_ovf), 32'd1);
        check("dn_w_q", 32'(w_q), 32'd8);
        check("dn_w_tcp", 32'(w_tcp), 32'd0);

        // Load with clamp: D=14 -> 9, no count despite EN.
        ld = 1'b1; d = 4'd14; up = 1'b1;
        step();
        check("clamp_w_q", 32'(w_q), 32'd9);
        check("clamp_s_tcp", 32'(s_tcp), 32'd0);
        check("clamp_s_ovf", 32'(s_ovf), 32'd1);
        ld = 1'b0;
        step();
        check("clamp_next_w_q", 32'(w_q), 32'd0);
        check("clamp_next_w_tcp", 32'(w_tcp), 32'd1);

        // OVF set/clear race.
        ld = 1'b1; d = 4'd9; clr = 1'b1;
        step();
        check("race_pre_ovf", 32'(w_ovf), 32'd0);
        check("cao_during_ld", 32'(w_cao), 32'd1);
        ld = 1'b0;
        step();
        check("race_w_ovf", 32'(w_ovf), 32'd1);
        check("race_w_q", 32'(w_q), 32'd0);
        en = 1'b0;
        step();
        check("clr_w_ovf", 32'(w_ovf), 32'd0);
        check("clr_s_ovf", 32'(s_ovf), 32'd0);
        clr = 1'b0;

        // CAI low blocks counting.
        en = 1'b1; cai = 1'b0;
        repeat (2) step();
        check("cai0_w_q", 32'(w_q), 32'd0);
        cai = 1'b1; en = 1'b0;

        // Two-digit cascade, 100 edges from 00.
        c_en = 1'b1;
        n_hi_pulse = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (hi_tcp === 1'b1) n_hi_pulse++;
            if (k == 99) begin
                check("casc99_lo", 32'(lo_q), 32'd9);
                check("casc99_hi", 32'(hi_q), 32'd9);
            end
        end
        check("casc100_lo", 32'(lo_q), 32'd0);
        check("casc100_hi", 32'(hi_q), 32'd0);
        check("casc_hi_pulses", 32'(n_hi_pulse), 32'd1);
        c_en = 1'b0;

        // Async reset mid-count at Q=7 with OVF set.
        en = 1'b1; up = 1'b1;
        repeat (17) step();
        check("pre_rst_w_q", 32'(w_q), 32'd7);
        check("pre_rst_w_ovf", 32'(w_ovf), 32'd1);
        #1;
        cdn = 1'b0;
        #1;
        check("arst_w_q", 32'(w_q), 32'd0);
        check("arst_w_ovf", 32'(w_ovf), 32'd0);
        check("arst_s_q", 32'(s_q), 32'd0);
        check("arst_s_tcp", 32'(s_tcp), 32'd0);
        repeat (3) step();
        check("held_w_q", 32'(w_q), 32'd0);
        cdn = 1'b1;
        repeat (2) step();
        check("post_rst_w_q", 32'(w_q), 32'd2);

        en = 1'b0;
        step();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
